// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encoding and phase state codes for the intersection scheduler
package traffic_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    A_CLR = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    B_CLR = 3'd5,
    WALK  = 3'd6
  } phase_e;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - saturating elapsed-tick counter with synchronous clear
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  output logic [CNT_W-1:0] count
);

  // Clear has priority over counting so a new phase always starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road phase scheduler with preemption; optional PED_WALK_EN pedestrian phase
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 1,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       preempt_req,
  input  logic       preempt_dir,
  input  logic       ped_req,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       preempt_ack,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] CLR_M1 = CNT_W'(ALL_RED_T - 1);

  phase_e           state;
  phase_e           state_next;
  phase_e           req_green;
  logic [CNT_W-1:0] elapsed;
  logic             ped_latch;

  assign req_green = preempt_dir ? B_GRN : A_GRN;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_next != state),
    .tick  (tick),
    .count (elapsed)
  );

`ifdef PED_WALK_EN
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

  // Sticky pedestrian request; consumed when the WALK phase is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_latch <= 1'b0;
    end else if ((state_next == WALK) && (state != WALK)) begin
      ped_latch <= 1'b0;
    end else if (ped_req) begin
      ped_latch <= 1'b1;
    end
  end
`else
  logic ped_unused;
  assign ped_latch  = 1'b0;
  assign ped_unused = ped_req ^ (WALK_T == 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= A_GRN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: preemption acts every cycle, timed exits only on tick.
  always_comb begin
    state_next = state;
    case (state)
      A_GRN: begin
        if (preempt_req) begin
          if (preempt_dir) state_next = A_YEL;
        end else if (tick && TB && (((elapsed >= MIN_M1) && !TA) || (elapsed >= MAX_M1))) begin
          state_next = A_YEL;
        end
      end
      A_YEL: begin
        if (tick && (elapsed == YEL_M1)) state_next = A_CLR;
      end
      A_CLR: begin
        if (tick && (elapsed == CLR_M1)) state_next = preempt_req ? req_green : B_GRN;
      end
      B_GRN: begin
        if (preempt_req) begin
          if (!preempt_dir) state_next = B_YEL;
        end else if (tick && TA && (((elapsed >= MIN_M1) && !TB) || (elapsed >= MAX_M1))) begin
          state_next = B_YEL;
        end
      end
      B_YEL: begin
        if (tick && (elapsed == YEL_M1)) state_next = B_CLR;
      end
      B_CLR: begin
        if (tick && (elapsed == CLR_M1)) begin
          if (preempt_req) state_next = req_green;
          else if (ped_latch) state_next = WALK;
          else state_next = A_GRN;
        end
      end
`ifdef PED_WALK_EN
      WALK: begin
        if (preempt_req) state_next = req_green;
        else if (tick && (elapsed == WALK_M1)) state_next = A_GRN;
      end
`endif
      default: state_next = A_GRN;
    endcase
  end

  // Output decode straight from the registered state.
  always_comb begin
    LA          = LT_RED;
    LB          = LT_RED;
    walk        = 1'b0;
    phase       = state;
    preempt_ack = preempt_req && (preempt_dir ? (state == B_GRN) : (state == A_GRN));
    case (state)
      A_GRN: LA = LT_GREEN;
      A_YEL: LA = LT_YELLOW;
      B_GRN: LB = LT_GREEN;
      B_YEL: LB = LT_YELLOW;
`ifdef PED_WALK_EN
      WALK:  walk = 1'b1;
`endif
      default: begin
        LA = LT_RED;
        LB = LT_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - vector table, directed sequences and random model comparison
module tb_traffic_phase_scheduler;

  localparam int CNT_W     = 8;
  localparam int MIN_GREEN = 8;
  localparam int MAX_GREEN = 32;
  localparam int YELLOW_T  = 3;
  localparam int ALL_RED_T = 1;
  localparam int WALK_T    = 6;

  logic       clk = 1'b0;
  logic       rst_n, tick, ta, tb, preq, pdir, ped_req;
  logic [1:0] la, lb;
  logic       ack, walk;
  logic [2:0] phase;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_T(YELLOW_T), .ALL_RED_T(ALL_RED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .TA(ta), .TB(tb),
    .preempt_req(preq), .preempt_dir(pdir), .ped_req(ped_req),
    .LA(la), .LB(lb), .preempt_ack(ack), .walk(walk), .phase(phase)
  );

  typedef struct {
    logic       rst_n, tick, ta, tb, preq, pdir;
    logic [1:0] la, lb;
    logic [2:0] ph;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic add(input logic r, tk, a, b, pq, pd, input logic [1:0] xla, xlb,
                     input logic [2:0] xph, input logic xack);
    vec_t v;
    v.rst_n = r; v.tick = tk; v.ta = a; v.tb = b; v.preq = pq; v.pdir = pd;
    v.la = xla; v.lb = xlb; v.ph = xph; v.ack = xack;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, tk, a, b, pq, pd, pr);
    rst_n = r; tick = tk; ta = a; tb = b; preq = pq; pdir = pd; ped_req = pr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural reference: which road owns the cycle and which stage of it we are in.
  int m_road, m_stage, m_cnt;
  bit m_ped;

  task automatic model_step(input bit r, tk, a, b, pq, pd, pr);
    int road_n, stage_n;
    bit own, other;
    if (!r) begin
      m_road = 0; m_stage = 0; m_cnt = 0; m_ped = 0;
      return;
    end
    road_n = m_road; stage_n = m_stage;
    own    = (m_road == 0) ? a : b;
    other  = (m_road == 0) ? b : a;
    case (m_stage)
      0: if (pq) begin
           if (int'(pd) != m_road) stage_n = 1;
         end else if (tk && other && ((m_cnt >= MIN_GREEN - 1 && !own) || m_cnt >= MAX_GREEN - 1)) begin
           stage_n = 1;
         end
      1: if (tk && m_cnt == YELLOW_T - 1) stage_n = 2;
      2: if (tk && m_cnt == ALL_RED_T - 1) begin
           if (pq) begin road_n = int'(pd); stage_n = 0; end
           else if (m_road == 1 && m_ped) begin road_n = 0; stage_n = 3; end
           else begin road_n = 1 - m_road; stage_n = 0; end
         end
      default: if (pq) begin road_n = int'(pd); stage_n = 0; end
               else if (tk && m_cnt == WALK_T - 1) begin road_n = 0; stage_n = 0; end
    endcase
`ifdef PED_WALK_EN
    if (stage_n == 3 && m_stage != 3) m_ped = 0;
    else if (pr) m_ped = 1;
`endif
    if (road_n != m_road || stage_n != m_stage) m_cnt = 0;
    else if (tk && m_cnt < 255) m_cnt++;
    m_road = road_n; m_stage = stage_n;
  endtask

  function automatic int model_out(input bit pq, pd);
    int xla, xlb, xph, xack, xwalk;
    xla = 2; xlb = 2;
    if (m_stage < 2) begin
      if (m_road == 0) xla = m_stage; else xlb = m_stage;
    end
    xph   = (m_stage == 3) ? 6 : m_road * 3 + m_stage;
    xack  = (pq && m_stage == 0 && int'(pd) == m_road) ? 1 : 0;
    xwalk = (m_stage == 3) ? 1 : 0;
    return (xla << 7) | (xlb << 5) | (xph << 2) | (xack << 1) | xwalk;
  endfunction

  initial begin
    int n, bad;
    bit r, tk, a, b, pq, pd, pr;
    rst_n = 0; tick = 0; ta = 0; tb = 0; preq = 0; pdir = 0; ped_req = 0;

    // Table: min-green exit, clear timing, preempt in green/yellow/clear, held green past max.
    add(0, 1, 0, 1, 0, 0, 2'b00, 2'b10, 3'd0, 0);
    for (int i = 0; i < 7; i++) add(1, 1, 0, 1, 0, 0, 2'b00, 2'b10, 3'd0, 0);
    add(1, 1, 0, 1, 0, 0, 2'b01, 2'b10, 3'd1, 0);
    for (int i = 0; i < 2; i++) add(1, 1, 0, 1, 0, 0, 2'b01, 2'b10, 3'd1, 0);
    add(1, 1, 0, 1, 0, 0, 2'b10, 2'b10, 3'd2, 0);
    add(1, 1, 0, 1, 0, 0, 2'b10, 2'b00, 3'd3, 0);
    add(1, 0, 0, 1, 1, 0, 2'b10, 2'b01, 3'd4, 0);
    add(1, 0, 0, 1, 1, 0, 2'b10, 2'b01, 3'd4, 0);
    add(1, 1, 0, 1, 1, 0, 2'b10, 2'b01, 3'd4, 0);
    add(1, 1, 0, 1, 1, 0, 2'b10, 2'b01, 3'd4, 0);
    add(1, 1, 0, 1, 1, 0, 2'b10, 2'b10, 3'd5, 0);
    add(1, 1, 0, 1, 1, 1, 2'b10, 2'b00, 3'd3, 1);
    for (int i = 0; i < 40; i++) add(1, 1, 1, 0, 1, 1, 2'b10, 2'b00, 3'd3, 1);
    add(1, 1, 1, 1, 0, 0, 2'b10, 2'b01, 3'd4, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].tick, vecs[i].ta, vecs[i].tb, vecs[i].preq, vecs[i].pdir, 0);
      check($sformatf("vec%0d_la", i), la, vecs[i].la);
      check($sformatf("vec%0d_lb", i), lb, vecs[i].lb);
      check($sformatf("vec%0d_phase", i), phase, vecs[i].ph);
      check($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
    end

    // Reset state, then A holds green for 100 ticks with no B traffic.
    step(0, 0, 1, 0, 0, 0, 0);
    check("reset_la", la, 0);
    check("reset_lb", lb, 2);
    check("reset_phase", phase, 0);
    check("reset_ack", ack, 0);
    check("reset_walk", walk, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 1, 0, 0, 0, 0);
      if (la != 2'b00 || lb != 2'b10 || phase != 3'd0) bad++;
    end
    check("hold_a_100_bad_cycles", bad, 0);

    // Max green with both roads busy, then B symmetric.
    step(0, 0, 1, 1, 0, 0, 0);
    n = 0;
    do begin step(1, 1, 1, 1, 0, 0, 0); n++; end while (la != 2'b01 && n < 100);
    check("max_green_a_ticks", n, MAX_GREEN);
    n = 0;
    do begin step(1, 1, 1, 1, 0, 0, 0); n++; end while (lb != 2'b00 && n < 100);
    check("a_yel_clr_ticks", n, YELLOW_T + ALL_RED_T);
    n = 0;
    do begin step(1, 1, 1, 1, 0, 0, 0); n++; end while (lb != 2'b01 && n < 100);
    check("max_green_b_ticks", n, MAX_GREEN);

    // Preempt toward B while A green at e=2: yellow on the very next edge without a tick.
    step(0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 0);
    check("preempt_b_yellow_next_edge", phase, 1);
    n = 0;
    do begin step(1, 1, 1, 1, 1, 1, 0); n++; end while (phase != 3'd3 && n < 100);
    check("preempt_b_to_green_ticks", n, YELLOW_T + ALL_RED_T);
    check("preempt_b_ack", ack, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1, 1, 1, 1, 1, 1, 0);
      if (phase != 3'd3 || ack != 1'b1) bad++;
    end
    check("preempt_b_hold_bad_cycles", bad, 0);

    // Reset wins over tick and preemption on the same edge.
    step(0, 1, 1, 1, 1, 1, 0);
    check("reset_mid_phase_phase", phase, 0);
    check("reset_mid_phase_la", la, 0);
    check("reset_mid_phase_ack", ack, 0);

    // Preempt toward A during A yellow: yellow completes, then A_CLR returns to A_GRN.
    for (int i = 0; i < MIN_GREEN; i++) step(1, 1, 0, 1, 0, 0, 0);
    check("a_yel_after_min", phase, 1);
    step(1, 0, 0, 1, 1, 0, 0);
    check("a_yel_not_skipped", phase, 1);
    for (int i = 0; i < YELLOW_T; i++) step(1, 1, 0, 1, 1, 0, 0);
    check("a_yel_completes", phase, 2);
    step(1, 1, 0, 1, 1, 0, 0);
    check("a_clr_back_to_a", phase, 0);
    check("a_clr_back_to_a_ack", ack, 1);

`ifdef PED_WALK_EN
    // Pedestrian request during B green leads to WALK after B_CLR; reset aborts WALK.
    for (int rep = 0; rep < 2; rep++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < MIN_GREEN + YELLOW_T + ALL_RED_T; i++) step(1, 1, 0, 1, 0, 0, 0);
      check("walk_reach_b", phase, 3);
      step(1, 0, 1, 0, 0, 0, 1);
      n = 0;
      do begin step(1, 1, 1, 0, 0, 0, 0); n++; end while (phase != 3'd6 && n < 100);
      check("walk_entered", walk, 1);
      if (rep == 0) begin
        n = 0;
        do begin step(1, 1, 1, 0, 0, 0, 0); n++; end while (phase == 3'd6 && n < 100);
        check("walk_ticks", n, WALK_T);
        check("walk_exit_phase", phase, 0);
        check("walk_exit_lamp", walk, 0);
      end else begin
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("walk_reset_phase", phase, 0);
        check("walk_reset_lamp", walk, 0);
      end
    end
`endif

    // Random stimulus against the reference model.
    r = 0; tk = 0; a = 0; b = 0; pq = 0; pd = 0; pr = 0;
    for (int i = 0; i < 4000; i++) begin
      r  = (i == 0) ? 1'b0 : ($urandom_range(0, 399) != 0);
      tk = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) a = ~a;
      if ($urandom_range(0, 9) == 0) b = ~b;
      if ($urandom_range(0, 39) == 0) pq = ~pq;
      if ($urandom_range(0, 29) == 0) pd = ~pd;
      pr = ($urandom_range(0, 39) == 0);
      model_step(r, tk, a, b, pq, pd, pr);
      step(r, tk, a, b, pq, pd, pr);
      check($sformatf("rand%0d_outputs", i), {la, lb, phase, ack, walk}, model_out(pq, pd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
